// File: rtl/clk_div_prog_mc_if.sv
// Control/status bundle for the programmable multi-channel clock divider.
interface clk_div_prog_mc_if #(
  parameter int unsigned NCH = 4,
  parameter int unsigned W   = 16
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] en;
  logic           sync;
  logic           ld;
  logic [CW-1:0]  ld_ch;
  logic [W-1:0]   ld_div;
  logic [W-1:0]   ld_hi;
  logic           ld_err;
  logic [NCH-1:0] y;
  logic [NCH-1:0] tick;

  modport master (
    output en, sync, ld, ld_ch, ld_div, ld_hi,
    input  ld_err, y, tick
  );

  modport slave (
    input  en, sync, ld, ld_ch, ld_div, ld_hi,
    output ld_err, y, tick
  );
endinterface

// File: rtl/clk_div_prog_mc.sv
// Multi-channel run-time programmable clock divider / tick generator.
// Each channel counts 0..div-1; new divisors go to a shadow and take effect at
// the end of the running period (or at once when the channel is idle / synced).
module clk_div_prog_mc #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned W           = 16,
  parameter int unsigned DEFAULT_DIV = 256,
  parameter int unsigned DEFAULT_HI  = 128
) (
  input  logic              clk,
  input  logic              rst,
  clk_div_prog_mc_if.slave  bus_if
);
  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [W-1:0]   cnt_q  [NCH];
  logic [W-1:0]   cnt_d  [NCH];
  logic [W-1:0]   div_q  [NCH];
  logic [W-1:0]   div_d  [NCH];
  logic [W-1:0]   hi_q   [NCH];
  logic [W-1:0]   hi_d   [NCH];
  logic [W-1:0]   pdiv_q [NCH];
  logic [W-1:0]   pdiv_d [NCH];
  logic [W-1:0]   phi_q  [NCH];
  logic [W-1:0]   phi_d  [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] y_q, y_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic           ld_err_q, ld_err_d;
  logic [NCH-1:0] wrap_c;
  logic           ld_ok_c;

  // A load is accepted only for an existing channel with a usable divisor/high time.
  assign ld_ok_c = bus_if.ld && (32'(bus_if.ld_ch) < NCH) &&
                   (bus_if.ld_div >= W'(2)) && (bus_if.ld_hi <= bus_if.ld_div);

  // Per-channel next state: sync beats apply-at-wrap beats normal counting.
  always_comb begin
    wrap_c   = '0;
    pend_d   = pend_q;
    y_d      = y_q;
    tick_d   = '0;
    ld_err_d = bus_if.ld && !ld_ok_c;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      hi_d[i]   = hi_q[i];
      pdiv_d[i] = pdiv_q[i];
      phi_d[i]  = phi_q[i];

      wrap_c[i] = bus_if.en[i] && (cnt_q[i] == div_q[i] - W'(1));
      if (bus_if.en[i]) begin
        y_d[i] = (cnt_q[i] < hi_q[i]);
      end
      tick_d[i] = wrap_c[i] && !bus_if.sync;

      if (bus_if.sync || (pend_q[i] && (!bus_if.en[i] || wrap_c[i]))) begin
        cnt_d[i] = '0;
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          hi_d[i]   = phi_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (bus_if.en[i]) begin
        cnt_d[i] = wrap_c[i] ? '0 : cnt_q[i] + W'(1);
      end

      // Capture after apply so a same-cycle load stays pending for the next wrap.
      if (ld_ok_c && (bus_if.ld_ch == CW'(i))) begin
        pdiv_d[i] = bus_if.ld_div;
        phi_d[i]  = bus_if.ld_hi;
        pend_d[i] = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= W'(DEFAULT_DIV);
        hi_q[i]   <= W'(DEFAULT_HI);
        pdiv_q[i] <= W'(DEFAULT_DIV);
        phi_q[i]  <= W'(DEFAULT_HI);
      end
      pend_q   <= '0;
      y_q      <= '0;
      tick_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        hi_q[i]   <= hi_d[i];
        pdiv_q[i] <= pdiv_d[i];
        phi_q[i]  <= phi_d[i];
      end
      pend_q   <= pend_d;
      y_q      <= y_d;
      tick_q   <= tick_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bus_if.y      = y_q;
  assign bus_if.tick   = tick_q;
  assign bus_if.ld_err = ld_err_q;

endmodule

// File: tb/tb_clk_div_prog_mc.sv
// Directed bench for clk_div_prog_mc (3 channels so that ld_ch can be out of range).
module tb_clk_div_prog_mc;
  localparam int NCH = 3;
  localparam int W   = 16;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  // Expected per-channel settings and count (count value before the next edge).
  int exp_cnt  [NCH];
  int exp_div  [NCH];
  int exp_hi   [NCH];
  int exp_pdiv [NCH];
  int exp_phi  [NCH];
  int exp_pend [NCH];

  clk_div_prog_mc_if #(.NCH(NCH), .W(W)) bus_if ();

  clk_div_prog_mc #(
    .NCH(NCH), .W(W), .DEFAULT_DIV(256), .DEFAULT_HI(128)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_defaults();
    for (int c = 0; c < NCH; c++) begin
      exp_cnt[c]  = 0;
      exp_div[c]  = 256;
      exp_hi[c]   = 128;
      exp_pend[c] = 0;
      exp_pdiv[c] = 256;
      exp_phi[c]  = 128;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    check("rst_y", 32'(bus_if.y), 32'h0);
    check("rst_tick", 32'(bus_if.tick), 32'h0);
    check("rst_ld_err", 32'(bus_if.ld_err), 32'h0);
    rst = 1'b0;
    exp_defaults();
  endtask

  // Runs n edges with all channels enabled, checking y/tick each edge.
  task automatic run_chk(input string tag, input int n);
    logic [NCH-1:0] ey;
    logic [NCH-1:0] et;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < NCH; c++) begin
        ey[c] = (exp_cnt[c] < exp_hi[c]);
        et[c] = (exp_cnt[c] == exp_div[c] - 1);
        if (et[c]) begin
          exp_cnt[c] = 0;
          if (exp_pend[c] != 0) begin
            exp_div[c]  = exp_pdiv[c];
            exp_hi[c]   = exp_phi[c];
            exp_pend[c] = 0;
          end
        end else begin
          exp_cnt[c]++;
        end
      end
      step();
      check({tag, "_y"}, 32'(bus_if.y), 32'(ey));
      check({tag, "_tick"}, 32'(bus_if.tick), 32'(et));
    end
  endtask

  task automatic load(input int ch, input int dv, input int hv);
    bus_if.ld     = 1'b1;
    bus_if.ld_ch  = 2'(ch);
    bus_if.ld_div = W'(dv);
    bus_if.ld_hi  = W'(hv);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus_if.en = '0;
    bus_if.sync = 1'b0;
    bus_if.ld = 1'b0;
    bus_if.ld_ch = '0;
    bus_if.ld_div = '0;
    bus_if.ld_hi = '0;

    // 1: defaults after reset, 128 high / 128 low, tick every 256.
    do_reset();
    bus_if.en = 3'b111;
    run_chk("t1", 512);

    // 2: load ch0 4/1 while idle, then enable.
    bus_if.en = '0;
    do_reset();
    load(0, 4, 1);
    step();
    bus_if.ld = 1'b0;
    check("t2_ld_err", 32'(bus_if.ld_err), 32'h0);
    step();
    check("t2_hold_y", 32'(bus_if.y), 32'h0);
    exp_div[0] = 4;
    exp_hi[0]  = 1;
    bus_if.en = 3'b111;
    run_chk("t2", 16);

    // 3: mid-period load ch1 6/3 at count 100; old period completes first.
    do_reset();
    bus_if.en = 3'b111;
    run_chk("t3pre", 100);
    load(1, 6, 3);
    exp_pend[1] = 1;
    exp_pdiv[1] = 6;
    exp_phi[1]  = 3;
    run_chk("t3ld", 1);
    bus_if.ld = 1'b0;
    run_chk("t3", 180);

    // 4: invalid loads flagged; hi=0 and hi=div boundaries accepted.
    bus_if.en = '0;
    do_reset();
    load(0, 1, 0);
    step();
    check("t4_err_div1", 32'(bus_if.ld_err), 32'h1);
    load(0, 4, 5);
    step();
    check("t4_err_hi", 32'(bus_if.ld_err), 32'h1);
    load(3, 4, 1);
    step();
    check("t4_err_ch", 32'(bus_if.ld_err), 32'h1);
    load(1, 2, 0);
    step();
    check("t4_ok_hi0", 32'(bus_if.ld_err), 32'h0);
    load(2, 2, 2);
    step();
    check("t4_ok_hidiv", 32'(bus_if.ld_err), 32'h0);
    bus_if.ld = 1'b0;
    step();
    check("t4_err_clr", 32'(bus_if.ld_err), 32'h0);
    exp_div[1] = 2; exp_hi[1] = 0;
    exp_div[2] = 2; exp_hi[2] = 2;
    bus_if.en = 3'b111;
    run_chk("t4", 20);

    // 5: 3/5/7 channels, sync realigns, ticks coincide after 105 cycles.
    bus_if.en = '0;
    do_reset();
    load(0, 3, 1);
    step();
    load(1, 5, 2);
    step();
    load(2, 7, 3);
    step();
    bus_if.ld = 1'b0;
    step();
    exp_div[0] = 3; exp_hi[0] = 1;
    exp_div[1] = 5; exp_hi[1] = 2;
    exp_div[2] = 7; exp_hi[2] = 3;
    bus_if.en = 3'b111;
    run_chk("t5pre", 11);
    bus_if.sync = 1'b1;
    step();
    bus_if.sync = 1'b0;
    check("t5_sync_tick", 32'(bus_if.tick), 32'h0);
    check("t5_sync_y", 32'(bus_if.y), 32'h2);
    for (int c = 0; c < NCH; c++) exp_cnt[c] = 0;
    run_chk("t5", 105);
    check("t5_lcm", 32'(bus_if.tick), 32'h7);

    // 6: async reset between edges discards a pending load.
    run_chk("t6pre", 1);
    check("t6_y_all", 32'(bus_if.y), 32'h7);
    load(1, 9, 4);
    exp_pend[1] = 1;
    exp_pdiv[1] = 9;
    exp_phi[1]  = 4;
    run_chk("t6ld", 1);
    bus_if.ld = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_y", 32'(bus_if.y), 32'h0);
    check("t6_async_tick", 32'(bus_if.tick), 32'h0);
    check("t6_async_err", 32'(bus_if.ld_err), 32'h0);
    step();
    rst = 1'b0;
    exp_defaults();
    run_chk("t6", 270);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
